mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle of pipeline-side request signals and the data-memory port used by
// mem_access_ctrl. The slave modport is the controller's view; the master
// modport is the view of whatever drives requests and memory responses.
interface mem_access_ctrl_if;
  // Pipeline M-stage inputs
  logic       readMemFlag;
  logic       writeMemFlag;
  logic [7:0] ALUResult;
  logic [7:0] regB;
  logic       flush;
  // Data memory port
  logic       memReq;
  logic       memWe;
  logic [7:0] memAddr;
  logic [7:0] memWData;
  logic       memAck;
  logic [7:0] memRData;
  // Pipeline feedback
  logic       stall;
  logic [7:0] loadData;
  logic       loadValid;
  logic       memErr;
  // FSM state for observation (0 = IDLE, 1 = BUSY, 2 = DONE)
  logic [1:0] dbg_state;

  // Handshake: memReq is a level request held with stable memWe/memAddr/
  // memWData until the single-cycle memAck pulse completes it; memAck is
  // only honoured while the controller is BUSY.
  modport slave (
    input  readMemFlag, writeMemFlag, ALUResult, regB, flush,
    input  memAck, memRData,
    output memReq, memWe, memAddr, memWData,
    output stall, loadData, loadValid, memErr, dbg_state
  );

  modport master (
    output readMemFlag, writeMemFlag, ALUResult, regB, flush,
    output memAck, memRData,
    input  memReq, memWe, memAddr, memWData,
    input  stall, loadData, loadValid, memErr, dbg_state
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage data memory access controller: turns a load/store in the M stage
// into a registered request/ack transaction, stalls the pipeline while the
// access is in flight, reports illegal requests and memory timeouts through
// a sticky error flag.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15  // max memReq-high cycles, 1..255
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the last permitted BUSY cycle without an ack
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       mem_req_q;
  logic       mem_we_q;
  logic [7:0] mem_addr_q;
  logic [7:0] mem_wdata_q;
  logic [7:0] load_data_q;
  logic       load_valid_q;
  logic       mem_err_q;

  logic start;      // legal access accepted this cycle
  logic illegal;    // both flags high, not flushed
  logic ack_done;   // access completes this cycle
  logic timed_out;  // access abandoned this cycle

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle event decode
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    illegal   = 1'b0;
    ack_done  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush) begin
          if (bus.readMemFlag ^ bus.writeMemFlag) begin
            start   = 1'b1;
            state_d = BUSY;
          end else if (bus.readMemFlag && bus.writeMemFlag) begin
            illegal = 1'b1;
          end
        end
      end
      BUSY: begin
        // An ack on the timeout cycle still counts as completion
        if (bus.memAck) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, timeout counter, load result and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 8'd0;
      mem_wdata_q  <= 8'd0;
      load_data_q  <= 8'd0;
      load_valid_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      if (start) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.writeMemFlag;
        mem_addr_q  <= bus.ALUResult;
        mem_wdata_q <= bus.regB;
        cnt_q       <= 8'd0;
      end
      if (state_q == BUSY && !ack_done && !timed_out) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (ack_done) begin
        mem_req_q <= 1'b0;
        if (!mem_we_q) begin
          load_data_q  <= bus.memRData;
          load_valid_q <= 1'b1;
        end
      end
      if (timed_out) begin
        mem_req_q <= 1'b0;
        mem_err_q <= 1'b1;
      end
      if (illegal) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  // Stall covers the accepting IDLE cycle and every BUSY cycle
  always_comb begin
    bus.stall = start || (state_q == BUSY);
  end

  assign bus.memReq    = mem_req_q;
  assign bus.memWe     = mem_we_q;
  assign bus.memAddr   = mem_addr_q;
  assign bus.memWData  = mem_wdata_q;
  assign bus.loadData  = load_data_q;
  assign bus.loadValid = load_valid_q;
  assign bus.memErr    = mem_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with TIMEOUT=4: a per-cycle vector table for
// loads, stores, illegal/flush requests and back-to-back traffic, followed
// by hand-written timeout and asynchronous-reset sequences.
module tb_mem_access_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rd, wr, fl, ack;
    logic [7:0] alu, regb, rdata;
    logic       e_req, e_we, e_stall, e_lv, e_err;
    logic [7:0] e_addr, e_wdata, e_ld;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rd, wr, fl, ack, input logic [7:0] alu, regb, rdata,
                     input logic e_req, e_we, e_stall, e_lv, e_err,
                     input logic [7:0] e_addr, e_wdata, e_ld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fl = fl; v.ack = ack;
    v.alu = alu; v.regb = regb; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_stall = e_stall; v.e_lv = e_lv; v.e_err = e_err;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_ld = e_ld;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rd, wr, fl, ack, input logic [7:0] alu, regb, rdata);
    bus.readMemFlag  = rd;
    bus.writeMemFlag = wr;
    bus.flush        = fl;
    bus.memAck       = ack;
    bus.ALUResult    = alu;
    bus.regB         = regb;
    bus.memRData     = rdata;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".memReq"},    8'(bus.memReq),    8'd0);
    chk({tag, ".memWe"},     8'(bus.memWe),     8'd0);
    chk({tag, ".memAddr"},   bus.memAddr,       8'd0);
    chk({tag, ".memWData"},  bus.memWData,      8'd0);
    chk({tag, ".loadData"},  bus.loadData,      8'd0);
    chk({tag, ".loadValid"}, 8'(bus.loadValid), 8'd0);
    chk({tag, ".memErr"},    8'(bus.memErr),    8'd0);
    chk({tag, ".stall"},     8'(bus.stall),     8'd0);
    chk({tag, ".state"},     8'(bus.dbg_state), 8'd0);
  endtask

  // One clock cycle: drive after the rising edge, sample on the falling edge
  task automatic cycle(input logic rd, wr, fl, ack, input logic [7:0] alu, regb, rdata);
    @(posedge clk);
    #1;
    drive(rd, wr, fl, ack, alu, regb, rdata);
    @(negedge clk);
  endtask

  initial begin
    int hi;
    bit seen_lv;
    checks = 0;
    errors = 0;
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    #2;
    chk_reset_state("reset0");
    @(negedge clk);
    #1 reset = 1'b0;

    //   rd wr fl ak alu    regb   rdata   req we st lv er addr   wdata  ld
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00); // idle
    add(1, 0, 0, 0, 8'h3C, 8'h00, 8'h00,  0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00); // load accepted
    add(1, 0, 1, 0, 8'h3C, 8'h00, 8'h00,  1, 0, 1, 0, 0, 8'h3C, 8'h00, 8'h00); // BUSY1, flush ignored
    add(1, 0, 0, 1, 8'h3C, 8'h00, 8'hA5,  1, 0, 1, 0, 0, 8'h3C, 8'h00, 8'h00); // BUSY2 ack
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 1, 0, 8'h00, 8'h00, 8'hA5); // DONE
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5); // idle
    add(0, 1, 0, 0, 8'h10, 8'h7E, 8'h00,  0, 0, 1, 0, 0, 8'h00, 8'h00, 8'hA5); // store accepted
    add(0, 1, 0, 1, 8'h10, 8'h7E, 8'h00,  1, 1, 1, 0, 0, 8'h10, 8'h7E, 8'hA5); // BUSY1 ack
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5); // DONE, no pulse
    add(0, 0, 0, 1, 8'h00, 8'h00, 8'hFF,  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5); // stray ack
    add(1, 1, 0, 0, 8'h40, 8'h00, 8'h00,  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5); // illegal
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hA5); // error set
    add(1, 0, 1, 0, 8'h50, 8'h00, 8'h00,  0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hA5); // flushed load
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hA5); // no request
    add(1, 1, 1, 0, 8'h50, 8'h00, 8'h00,  0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hA5); // flushed illegal
    add(1, 0, 0, 0, 8'h20, 8'h00, 8'h00,  0, 0, 1, 0, 1, 8'h00, 8'h00, 8'hA5); // b2b load
    add(1, 0, 1, 1, 8'h20, 8'h00, 8'h5A,  1, 0, 1, 0, 1, 8'h20, 8'h00, 8'hA5); // BUSY1 ack
    add(0, 1, 0, 0, 8'h30, 8'hC3, 8'h00,  0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h5A); // DONE ignores store
    add(0, 1, 0, 0, 8'h30, 8'hC3, 8'h00,  0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h5A); // store accepted
    add(0, 1, 0, 1, 8'h30, 8'hC3, 8'h00,  1, 1, 1, 0, 1, 8'h30, 8'hC3, 8'h5A); // BUSY1 ack
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h5A); // DONE
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h5A); // idle

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      cycle(v.rd, v.wr, v.fl, v.ack, v.alu, v.regb, v.rdata);
      chk($sformatf("row%0d.memReq", i),    8'(bus.memReq),    8'(v.e_req));
      chk($sformatf("row%0d.stall", i),     8'(bus.stall),     8'(v.e_stall));
      chk($sformatf("row%0d.loadValid", i), 8'(bus.loadValid), 8'(v.e_lv));
      chk($sformatf("row%0d.loadData", i),  bus.loadData,      v.e_ld);
      chk($sformatf("row%0d.memErr", i),    8'(bus.memErr),    8'(v.e_err));
      if (v.e_req) begin
        chk($sformatf("row%0d.memAddr", i), bus.memAddr,   v.e_addr);
        chk($sformatf("row%0d.memWe", i),   8'(bus.memWe), 8'(v.e_we));
        if (v.e_we) chk($sformatf("row%0d.memWData", i), bus.memWData, v.e_wdata);
      end
    end

    // Timeout: fresh reset, load with no ack, first access right after release
    @(posedge clk);
    #1 reset = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    #1;
    chk_reset_state("reset1");
    @(negedge clk);
    #1 reset = 1'b0;
    drive(1, 0, 0, 0, 8'h44, 8'h00, 8'h00);
    #1;
    chk("to.accept_stall", 8'(bus.stall), 8'd1);
    hi = 0;
    seen_lv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      if (bus.loadValid) seen_lv = 1'b1;
      if (bus.memReq) begin
        hi++;
        chk("to.busy_stall", 8'(bus.stall), 8'd1);
        chk("to.busy_addr", bus.memAddr, 8'h44);
      end else if (hi > 0) begin
        break;
      end
    end
    chk("to.req_cycles", 8'(hi), 8'd4);
    chk("to.memErr", 8'(bus.memErr), 8'd1);
    chk("to.stall_drop", 8'(bus.stall), 8'd0);
    chk("to.loadData", bus.loadData, 8'h00);
    chk("to.no_loadValid", 8'(seen_lv), 8'd0);
    // Next load completes normally with error still set
    cycle(1, 0, 0, 0, 8'h55, 8'h00, 8'h00);
    chk("to2.stall", 8'(bus.stall), 8'd1);
    cycle(0, 0, 0, 1, 8'h00, 8'h00, 8'h99);
    chk("to2.memReq", 8'(bus.memReq), 8'd1);
    chk("to2.memAddr", bus.memAddr, 8'h55);
    cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("to2.loadValid", 8'(bus.loadValid), 8'd1);
    chk("to2.loadData", bus.loadData, 8'h99);
    chk("to2.memErr", 8'(bus.memErr), 8'd1);

    // Reset in the middle of the second BUSY cycle
    cycle(1, 0, 0, 0, 8'h66, 8'h00, 8'h00);
    cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("rst.busy1_req", 8'(bus.memReq), 8'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_reset_state("rst.async");
    @(negedge clk);
    #1 reset = 1'b0;
    cycle(0, 0, 0, 1, 8'h00, 8'h00, 8'hEE);
    chk("rst.ack_req", 8'(bus.memReq), 8'd0);
    chk("rst.ack_stall", 8'(bus.stall), 8'd0);
    cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("rst.ack_lv", 8'(bus.loadValid), 8'd0);
    chk("rst.ack_ld", bus.loadData, 8'h00);
    chk("rst.ack_state", 8'(bus.dbg_state), 8'd0);
    cycle(1, 0, 0, 0, 8'h77, 8'h00, 8'h00);
    chk("rst.new_stall", 8'(bus.stall), 8'd1);
    cycle(0, 0, 0, 1, 8'h00, 8'h00, 8'h3E);
    chk("rst.new_req", 8'(bus.memReq), 8'd1);
    chk("rst.new_addr", bus.memAddr, 8'h77);
    cycle(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("rst.new_ld", bus.loadData, 8'h3E);
    chk("rst.new_err", 8'(bus.memErr), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
